// File: rtl/des_key_sched.sv
// des_key_sched: DES key schedule sequencer - PC-1 on load, per-round C/D rotation, PC-2 subkeys out.
// Latency: first subkey valid 2 cycles after key_load; each accepted subkey -> next one 2 cycles later.
// Backpressure: subkey_ready low holds state, subkey_out and round_idx stable indefinitely.
module des_key_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic [64:1] key_in,
    input  logic        key_load,
    input  logic        decrypt,
    output logic [48:1] subkey_out,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [4:0]  round_idx,
    output logic        busy,
    output logic        done
);
    // LOAD is kept in the encoding but never entered: loading happens on the IDLE exit edge.
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, PRESENT} state_t;

    // Entry i names the FIPS input bit (1 = MSB) that lands in output bit i+1.
    localparam int PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Vectors are numbered so that FIPS bit n sits at index (width+1-n).
    function automatic logic [56:1] pc1(input logic [64:1] k);
        logic [56:1] r;
        r = '0;
        for (int i = 0; i < 56; i++)
            r[6'(56 - i)] = k[7'(65 - PC1_TBL[6'(i)])];
        return r;
    endfunction

    function automatic logic [48:1] pc2(input logic [56:1] cd);
        logic [48:1] r;
        r = '0;
        for (int j = 0; j < 48; j++)
            r[6'(48 - j)] = cd[6'(57 - PC2_TBL[6'(j)])];
        return r;
    endfunction

    // Encrypt uses S[round]; decrypt skips round 1 and then walks the table backwards with S[18-round].
    function automatic logic [1:0] shift_amt(input logic [4:0] rnd, input logic dir);
        logic [4:0] s;
        if (dir && rnd == 5'd1)
            return 2'd0;
        s = dir ? (5'd18 - rnd) : rnd;
        return (s == 5'd1 || s == 5'd2 || s == 5'd9 || s == 5'd16) ? 2'd1 : 2'd2;
    endfunction

    function automatic logic [28:1] rot(input logic [28:1] v, input logic [1:0] amt, input logic right);
        logic [28:1] r;
        case ({right, amt})
            3'b001:  r = {v[27:1], v[28]};
            3'b010:  r = {v[26:1], v[28:27]};
            3'b101:  r = {v[1], v[28:2]};
            3'b110:  r = {v[2:1], v[28:3]};
            default: r = v;
        endcase
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [28:1] c_q, c_d, d_q, d_d;
    logic        dir_q, dir_d;
    logic [4:0]  round_q, round_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [1:0]  amt;

    // Next-state and next-output logic for the IDLE -> SHIFT <-> PRESENT sequence.
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        dir_d   = dir_q;
        round_d = round_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        amt     = 2'd0;
        case (state_q)
            IDLE: begin
                if (key_load) begin
                    {c_d, d_d} = pc1(key_in);
                    dir_d      = decrypt;
                    round_d    = 5'd1;
                    busy_d     = 1'b1;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                amt     = shift_amt(round_q, dir_q);
                c_d     = rot(c_q, amt, dir_q);
                d_d     = rot(d_q, amt, dir_q);
                valid_d = 1'b1;
                state_d = PRESENT;
            end
            PRESENT: begin
                if (subkey_ready) begin
                    valid_d = 1'b0;
                    if (round_q == 5'd16) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        round_d = 5'd0;
                    end else begin
                        round_d = round_q + 5'd1;
                        state_d = SHIFT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset wins over any sequence in progress and suppresses done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            c_q     <= '0;
            d_q     <= '0;
            dir_q   <= 1'b0;
            round_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            dir_q   <= dir_d;
            round_q <= round_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign subkey_out   = pc2({c_q, d_q});
    assign subkey_valid = valid_q;
    assign round_idx    = round_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_des_key_sched.sv
// Testbench for des_key_sched: random keys and backpressure against a cumulative-rotation key schedule model.
// Inputs driven and outputs sampled on the falling edge; the DUT samples on the rising edge.
// Directed steps cover FIPS vectors, decrypt order, ignored loads, mid-stall reset and back-to-back loads.
module tb_des_key_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic [64:1] key_in;
    logic        key_load;
    logic        decrypt;
    logic [48:1] subkey_out;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [4:0]  round_idx;
    logic        busy;
    logic        done;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;
    logic [47:0] first_k, last_k;

    localparam logic [63:0] FIPS_KEY = 64'h133457799BBCDFF1;

    always #5 clk = ~clk;

    des_key_sched dut (
        .clk          (clk),
        .rst          (rst),
        .key_in       (key_in),
        .key_load     (key_load),
        .decrypt      (decrypt),
        .subkey_out   (subkey_out),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .round_idx    (round_idx),
        .busy         (busy),
        .done         (done)
    );

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // Encrypt subkey K(r): C and D rotated left by the total of the first r shifts, then PC-2.
    function automatic logic [47:0] ref_subkey(input logic [63:0] key, input int r);
        bit c [28];
        bit d [28];
        int tot;
        int p;
        logic [47:0] k;
        tot = 0;
        for (int i = 0; i < r; i++) tot += SHIFTS[i];
        for (int i = 0; i < 28; i++) begin
            c[i] = key[64 - PC1[i]];
            d[i] = key[64 - PC1[i + 28]];
        end
        k = '0;
        for (int j = 0; j < 48; j++) begin
            p = PC2[j] - 1;
            k[47 - j] = (p < 28) ? c[(p + tot) % 28] : d[(p - 28 + tot) % 28];
        end
        return k;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full schedule from the load cycle to the done cycle; returns with the bench at the done cycle
    // (hold=1) or one cycle after it. intrude pulses a foreign load while that output index is presented.
    task automatic run_sched(input logic [63:0] key, input bit dir, input int pct, input bit timing,
                             input int intrude, input bit hold, input logic [63:0] nxt_key);
        logic [47:0] ek [1:16];
        logic [47:0] exp_k;
        logic [47:0] held_k;
        logic [4:0]  held_i;
        bit stalled;
        int got;
        int cyc;
        stalled = 1'b0;
        got     = 0;
        held_k  = '0;
        held_i  = '0;
        for (int r = 1; r <= 16; r++) ek[r] = ref_subkey(key, r);
        key_in   = key;
        decrypt  = dir;
        key_load = 1'b1;
        @(negedge clk);
        cyc      = 1;
        key_in   = hold ? nxt_key : {$urandom, $urandom};
        decrypt  = hold ? 1'b0 : ~dir;
        while (got < 16 && cyc < 3000) begin
            key_load = hold;
            if (subkey_valid) begin
                exp_k = dir ? ek[16 - got] : ek[got + 1];
                if (stalled) begin
                    check("stall_key", subkey_out, held_k);
                    check("stall_idx", round_idx, held_i);
                end else begin
                    check("subkey", subkey_out, exp_k);
                    check("round_idx", round_idx, got + 1);
                    check("busy_run", busy, 1);
                    if (timing) check("latency", cyc, 2 * (got + 1));
                    if (got == 0) first_k = subkey_out;
                    if (got == 15) last_k = subkey_out;
                end
                if (intrude != 0 && round_idx == intrude && !stalled) begin
                    key_load = 1'b1;
                    key_in   = nxt_key;
                    decrypt  = 1'b1;
                end
                subkey_ready = ($urandom_range(99) < pct);
                if (subkey_ready) begin
                    got++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held_k  = subkey_out;
                    held_i  = round_idx;
                end
            end else begin
                subkey_ready = 1'($urandom_range(1));
            end
            @(negedge clk);
            cyc++;
        end
        subkey_ready = 1'b0;
        check("handshakes", got, 16);
        if (timing) check("done_cycle", cyc, 33);
        check("done_high", done, 1);
        check("busy_end", busy, 0);
        check("valid_end", subkey_valid, 0);
        check("idx_end", round_idx, 0);
        if (!hold) begin
            key_load = 1'b0;
            @(negedge clk);
            check("done_pulse", done, 0);
        end
    endtask

    initial begin
        logic [63:0] k2;
        int n;
        rst          = 1'b1;
        key_load     = 1'b0;
        decrypt      = 1'b0;
        subkey_ready = 1'b0;
        key_in       = '0;
        repeat (2) @(negedge clk);
        check("rst_valid", subkey_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_idx", round_idx, 0);
        check("rst_key", subkey_out, 0);
        rst = 1'b0;
        @(negedge clk);

        // FIPS example key, both directions, ready tied high.
        run_sched(FIPS_KEY, 1'b0, 100, 1'b1, 0, 1'b0, 64'd0);
        check("enc_k1", first_k, 48'h1B02EFFC7072);
        check("enc_k16", last_k, 48'hCB3D8B0E17F5);
        run_sched(FIPS_KEY, 1'b1, 100, 1'b1, 0, 1'b0, 64'd0);
        check("dec_first", first_k, 48'hCB3D8B0E17F5);
        check("dec_last", last_k, 48'h1B02EFFC7072);

        // Random keys under ~30% ready.
        for (int t = 0; t < 4; t++)
            run_sched({$urandom, $urandom}, t[0], 30, 1'b0, 0, 1'b0, 64'd0);
        run_sched(FIPS_KEY, 1'b0, 30, 1'b0, 0, 1'b0, 64'd0);
        check("bp_k1", first_k, 48'h1B02EFFC7072);

        // Foreign decrypt load at idx 5 must be ignored.
        run_sched(FIPS_KEY, 1'b0, 60, 1'b0, 5, 1'b0, {$urandom, $urandom});
        check("intr_k16", last_k, 48'hCB3D8B0E17F5);

        // Reset while idx 9 is stalled.
        key_in       = FIPS_KEY;
        decrypt      = 1'b0;
        key_load     = 1'b1;
        @(negedge clk);
        key_load     = 1'b0;
        subkey_ready = 1'b1;
        n = 0;
        while (!(subkey_valid && round_idx == 5'd9) && n < 100) begin
            @(negedge clk);
            n++;
        end
        subkey_ready = 1'b0;
        check("reach_idx9", round_idx, 9);
        repeat (2) @(negedge clk);
        check("stall_idx9", round_idx, 9);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_valid", subkey_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_idx", round_idx, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_key", subkey_out, 0);
        @(negedge clk);
        check("post_rst_done", done, 0);
        run_sched(FIPS_KEY, 1'b0, 100, 1'b1, 0, 1'b0, 64'd0);
        check("post_rst_k1", first_k, 48'h1B02EFFC7072);

        // Back-to-back schedules with key_load held high; second load lands in the done cycle.
        k2 = {$urandom, $urandom};
        run_sched(FIPS_KEY, 1'b0, 100, 1'b1, 0, 1'b1, k2);
        run_sched(k2, 1'b1, 100, 1'b1, 0, 1'b0, 64'd0);
        check("b2b_first", first_k, ref_subkey(k2, 16));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
